// File: rtl/menu_select.sv
// N-way menu cursor driven by synchronised, debounced push-buttons; center fires a one-cycle action pulse.
// Define MENU_SELECT_WRAP_EN for a wrap-around cursor; the default build saturates at both ends.
module menu_select #(
  parameter  int unsigned N_OPTS          = 2,
  parameter  int unsigned DEBOUNCE_CYCLES = 16,
  parameter  int unsigned INIT_SEL        = 1,
  localparam int unsigned IDX_W           = $clog2(N_OPTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_center,
  output logic [IDX_W-1:0]  sel_idx,
  output logic [N_OPTS-1:0] sel_onehot,
  output logic [N_OPTS-1:0] act_pulse,
  output logic              act_valid
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned N_BTN = 3;

  // Button order: 0 = next, 1 = prev, 2 = center.
  logic [N_BTN-1:0] w_btn;
  logic [N_BTN-1:0] w_rise;

  assign w_btn = {btn_center, btn_prev, btn_next};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_q;
    logic [CNT_W-1:0] r_cnt;

    // Level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1    <= 1'b0;
        r_sync2    <= 1'b0;
        r_stable   <= 1'b0;
        r_stable_q <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_sync1    <= w_btn[g];
        r_sync2    <= r_sync1;
        r_stable_q <= r_stable;
        if (r_sync2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= ~r_stable;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign w_rise[g] = r_stable & ~r_stable_q;
  end

  logic [IDX_W-1:0]  r_sel_idx;
  logic [N_OPTS-1:0] r_onehot;
  logic [N_OPTS-1:0] r_act;
  logic              r_act_valid;
  logic [IDX_W-1:0]  w_sel_nxt;
  logic [N_OPTS-1:0] w_act_nxt;

  // Cursor next-state; simultaneous next and prev cancel out.
  always_comb begin
    w_sel_nxt = r_sel_idx;
    w_act_nxt = '0;
    if (w_rise[0] && !w_rise[1]) begin
      if (r_sel_idx == IDX_W'(N_OPTS - 1)) begin
`ifdef MENU_SELECT_WRAP_EN
        w_sel_nxt = '0;
`else
        w_sel_nxt = r_sel_idx;
`endif
      end else begin
        w_sel_nxt = r_sel_idx + IDX_W'(1);
      end
    end else if (w_rise[1] && !w_rise[0]) begin
      if (r_sel_idx == '0) begin
`ifdef MENU_SELECT_WRAP_EN
        w_sel_nxt = IDX_W'(N_OPTS - 1);
`else
        w_sel_nxt = r_sel_idx;
`endif
      end else begin
        w_sel_nxt = r_sel_idx - IDX_W'(1);
      end
    end
    if (w_rise[2]) begin
      w_act_nxt = N_OPTS'(1) << r_sel_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_idx   <= IDX_W'(INIT_SEL);
      r_onehot    <= N_OPTS'(1) << IDX_W'(INIT_SEL);
      r_act       <= '0;
      r_act_valid <= 1'b0;
    end else begin
      r_sel_idx   <= w_sel_nxt;
      r_onehot    <= N_OPTS'(1) << w_sel_nxt;
      r_act       <= w_act_nxt;
      r_act_valid <= w_rise[2];
    end
  end

  assign sel_idx    = r_sel_idx;
  assign sel_onehot = r_onehot;
  assign act_pulse  = r_act;
  assign act_valid  = r_act_valid;

endmodule

// File: tb/tb_menu_select.sv
// Scoreboard bench for menu_select (N_OPTS=4, DEBOUNCE_CYCLES=4, INIT_SEL=1); honours MENU_SELECT_WRAP_EN.
module tb_menu_select;

  localparam int unsigned LAT = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_center;
  logic [1:0] sel_idx;
  logic [3:0] sel_onehot;
  logic [3:0] act_pulse;
  logic       act_valid;

  typedef struct {
    int         cyc;
    logic [3:0] act;
    logic [1:0] sel;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  menu_select #(.N_OPTS(4), .DEBOUNCE_CYCLES(4), .INIT_SEL(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .btn_center (btn_center),
    .sel_idx    (sel_idx),
    .sel_onehot (sel_onehot),
    .act_pulse  (act_pulse),
    .act_valid  (act_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the cursor moves or an action fires.
  initial begin : monitor
    logic [1:0] prev_sel;
    exp_t       e;
    prev_sel = 2'd1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        prev_sel = sel_idx;
      end else begin
        if (q.size() > 0 && cyc > q[0].cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missing_event: no event by cycle %0d, expected at %0d", cyc, q[0].cyc);
          void'(q.pop_front());
        end
        if (act_valid || act_pulse != 4'd0 || sel_idx != prev_sel) begin
          if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: cycle %0d sel=%0d act=%b valid=%b, expected none",
                     cyc, sel_idx, act_pulse, act_valid);
          end else begin
            e = q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("act_pulse", int'(act_pulse), int'(e.act));
            chk("act_valid", int'(act_valid), int'(|e.act));
            chk("sel_idx", int'(sel_idx), int'(e.sel));
            chk("sel_onehot", int'(sel_onehot), int'(4'd1 << e.sel));
          end
        end
        prev_sel = sel_idx;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive button mask b={center,prev,next} for hold samples, then release for rel cycles.
  task automatic press(input logic [2:0] b, input int hold, input int rel,
                       input bit ev, input logic [3:0] ea, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    {btn_center, btn_prev, btn_next} = b;
    if (ev) begin
      e.cyc = cyc + LAT;
      e.act = ea;
      e.sel = es;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
    {btn_center, btn_prev, btn_next} = 3'b000;
    repeat (rel) @(negedge clk);
  endtask

  initial begin : stim
    exp_t e;
    rst = 1'b1;
    {btn_center, btn_prev, btn_next} = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sel_idx", int'(sel_idx), 1);
    chk("reset_sel_onehot", int'(sel_onehot), 2);
    chk("reset_act_pulse", int'(act_pulse), 0);
    chk("reset_act_valid", int'(act_valid), 0);

    // Center held 20 cycles: a single action on option 1.
    press(3'b100, 20, 12, 1'b1, 4'b0010, 2'd1);

    // Three next presses: 2, 3, then wrap to 0 or saturate at 3.
    press(3'b001, 10, 10, 1'b1, 4'b0000, 2'd2);
    press(3'b001, 10, 10, 1'b1, 4'b0000, 2'd3);
`ifdef MENU_SELECT_WRAP_EN
    press(3'b001, 10, 10, 1'b1, 4'b0000, 2'd0);
    chk("next_wrap_sel", int'(sel_idx), 0);
`else
    press(3'b001, 10, 10, 1'b0, 4'b0000, 2'd3);
    chk("next_sat_sel", int'(sel_idx), 3);
`endif

    // Glitch one sample short of the debounce threshold.
    do_reset();
    press(3'b001, 3, 10, 1'b0, 4'b0000, 2'd1);
    chk("glitch_sel", int'(sel_idx), 1);

    // Next with center: action on old index, cursor moves same clock.
    press(3'b101, 10, 10, 1'b1, 4'b0010, 2'd2);
    press(3'b011, 10, 10, 1'b0, 4'b0000, 2'd2);
    chk("next_prev_cancel_sel", int'(sel_idx), 2);

    // Prev down to 0, then wrap to 3 or saturate.
    do_reset();
    press(3'b010, 10, 10, 1'b1, 4'b0000, 2'd0);
`ifdef MENU_SELECT_WRAP_EN
    press(3'b010, 10, 10, 1'b1, 4'b0000, 2'd3);
    chk("prev_wrap_sel", int'(sel_idx), 3);
`else
    press(3'b010, 10, 10, 1'b0, 4'b0000, 2'd0);
    chk("prev_sat_sel", int'(sel_idx), 0);
`endif

    // Reset three cycles into a prev hold, released while still held.
    @(negedge clk);
    btn_prev = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midpress_rst_sel", int'(sel_idx), 1);
    chk("midpress_rst_onehot", int'(sel_onehot), 2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e.cyc = cyc + LAT;
    e.act = 4'b0000;
    e.sel = 2'd0;
    q.push_back(e);
    repeat (15) @(negedge clk);
    btn_prev = 1'b0;
    repeat (12) @(negedge clk);
    chk("midpress_final_sel", int'(sel_idx), 0);

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
